// File: rtl/regfile_dump_controller_pkg.sv
// Shared constants for the register-file dump path.
// Covers bus geometry, the frame marker and the FSM state encodings.
package regfile_dump_controller_pkg;

  localparam int PROC_BITS      = 32;
  localparam int REG_ADDRS_BITS = 5;
  localparam int NUM_REGS       = 2 ** REG_ADDRS_BITS;
  localparam int BYTES_PER_REG  = PROC_BITS / 8;

  localparam logic [7:0] DEBUG_HEADER_BYTE = 8'hA5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_HEADER = 2'd1;
  localparam state_t ST_DATA   = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

endpackage

// File: rtl/regfile_dump_byte_mux.sv
// Selects one byte of a snapshot word for transmission.
// The byte order is chosen at build time.
module regfile_dump_byte_mux
  import regfile_dump_controller_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic [PROC_BITS-1:0] word,
  input  logic [1:0]           byte_idx,
  output logic [7:0]           byte_out
);

  logic [1:0] lane;

  // With MSB first, stream position 0 maps to the top byte lane.
  assign lane     = MSB_FIRST ? (2'd3 - byte_idx) : byte_idx;
  assign byte_out = word[8*lane +: 8];

endmodule

// File: rtl/regfile_dump_controller.sv
// Snapshots the register-file debug bus and streams it as a header byte followed by
// R0..R31 data bytes over a valid/ready handshake.
module regfile_dump_controller #(
  parameter int         PROC_BITS      = regfile_dump_controller_pkg::PROC_BITS,
  parameter int         REG_ADDRS_BITS = regfile_dump_controller_pkg::REG_ADDRS_BITS,
  parameter logic [7:0] HEADER_BYTE    = regfile_dump_controller_pkg::DEBUG_HEADER_BYTE,
  parameter bit         MSB_FIRST      = 1'b1
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic [PROC_BITS*PROC_BITS-1:0] i_debug_regs,
  input  logic                           i_start,
  output logic [7:0]                     o_tx_data,
  output logic                           o_tx_valid,
  input  logic                           i_tx_ready,
  output logic                           o_busy,
  output logic                           o_done
);

  import regfile_dump_controller_pkg::*;

  localparam int NREGS = 2 ** REG_ADDRS_BITS;

  state_t                    state;
  state_t                    state_next;
  logic [REG_ADDRS_BITS-1:0] reg_idx;
  logic [1:0]                byte_idx;
  logic [PROC_BITS-1:0]      snapshot [NREGS];
  logic                      start_accept;
  logic                      xfer;
  logic                      last_byte;
  logic [7:0]                data_byte;

  assign start_accept = (state == ST_IDLE) && i_start;
  assign xfer         = o_tx_valid && i_tx_ready;
  assign last_byte    = (reg_idx == REG_ADDRS_BITS'(NREGS - 1)) && (byte_idx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // NOTE: the default assignment on entry keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (i_start)            state_next = ST_HEADER;
      ST_HEADER: if (xfer)               state_next = ST_DATA;
      ST_DATA:   if (xfer && last_byte)  state_next = ST_DONE;
      ST_DONE:                           state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register, so reset clears them at once.
  always_comb begin
    o_tx_valid = 1'b0;
    o_tx_data  = '0;
    o_busy     = 1'b1;
    o_done     = 1'b0;
    case (state)
      ST_IDLE:   o_busy = 1'b0;
      ST_HEADER: begin
        o_tx_valid = 1'b1;
        o_tx_data  = HEADER_BYTE;
      end
      ST_DATA: begin
        o_tx_valid = 1'b1;
        o_tx_data  = data_byte;
      end
      ST_DONE:   o_done = 1'b1;
      default:   o_busy = 1'b0;
    endcase
  end

  // The 2-bit byte counter rolls 3->0 by itself; reg_idx wraps only on the final byte.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      reg_idx  <= '0;
      byte_idx <= '0;
    end else if (start_accept) begin
      reg_idx  <= '0;
      byte_idx <= '0;
    end else if ((state == ST_DATA) && xfer) begin
      byte_idx <= byte_idx + 2'd1;
      if (byte_idx == 2'd3) reg_idx <= reg_idx + 1'b1;
    end
  end

  // NOTE: the snapshot is a flop array, not a RAM macro, so it can take an async clear.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) snapshot[i] <= '0;
    end else if (start_accept) begin
      for (int i = 0; i < NREGS; i++) snapshot[i] <= i_debug_regs[i*PROC_BITS +: PROC_BITS];
    end
  end

  regfile_dump_byte_mux #(
    .MSB_FIRST (MSB_FIRST)
  ) u_byte_mux (
    .word     (snapshot[reg_idx]),
    .byte_idx (byte_idx),
    .byte_out (data_byte)
  );

endmodule

// File: tb/tb_regfile_dump_controller.sv
// Scoreboard bench for regfile_dump_controller: MSB-first instance under varied handshake,
// plus an LSB-first instance for byte-order checking.
module tb_regfile_dump_controller;

  localparam int W = 32;
  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*W-1:0] regs;
  logic           start = 1'b0;
  logic           tx_ready = 1'b0;
  logic [7:0]     tx_data;
  logic           tx_valid, busy, done;

  logic           start_lsb = 1'b0;
  logic           ready_lsb = 1'b1;
  logic [7:0]     tx_data_lsb;
  logic           tx_valid_lsb, busy_lsb, done_lsb;

  int         n_cmp = 0;
  int         n_mis = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_lsb_q[$];
  int         n_bytes, n_done, n_busy, n_bytes_lsb, n_done_lsb;
  bit         rand_ready = 1'b0;
  bit         held_valid = 1'b0;
  logic [7:0] held_data;
  bit         prev_xfer = 1'b0;

  regfile_dump_controller #(.MSB_FIRST(1'b1)) dut (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_debug_regs (regs),
    .i_start      (start),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .i_tx_ready   (tx_ready),
    .o_busy       (busy),
    .o_done       (done)
  );

  regfile_dump_controller #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk          (clk),
    .i_rst_n      (rst_n),
    .i_debug_regs (regs),
    .i_start      (start_lsb),
    .o_tx_data    (tx_data_lsb),
    .o_tx_valid   (tx_valid_lsb),
    .i_tx_ready   (ready_lsb),
    .o_busy       (busy_lsb),
    .o_done       (done_lsb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [N*W-1:0] r, input bit msb);
    int lane;
    if (msb) exp_q.push_back(9'h0A5);
    else     exp_lsb_q.push_back(9'h0A5);
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 4; k++) begin
        lane = msb ? (3 - k) : k;
        if (msb) exp_q.push_back({1'b0, r[i*W + lane*8 +: 8]});
        else     exp_lsb_q.push_back({1'b0, r[i*W + lane*8 +: 8]});
      end
    end
  endfunction

  task automatic set_regs_default();
    for (int i = 0; i < N; i++) regs[i*W +: W] = W'(i);
    regs[5*W +: W] = 32'hDEADBEEF;
  endtask

  // Handshake driver: ready changes just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Main-instance monitor: byte scoreboard, hold stability, done timing.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (!rst_n) begin
      held_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (held_valid) begin
        check("hold_valid", tx_valid, 1'b1);
        check("hold_data", tx_data, held_data);
      end
      if (done) begin
        n_done++;
        check("done_after_last", prev_xfer, 1'b1);
        check("done_queue_empty", exp_q.size(), 0);
      end
      if (busy) n_busy++;
      if (tx_valid && tx_ready) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h100;
        check("byte", {1'b0, tx_data}, exp);
        n_bytes++;
      end
      held_valid = tx_valid && !tx_ready;
      held_data  = tx_data;
      prev_xfer  = tx_valid && tx_ready;
    end
  end

  // LSB-first instance monitor.
  always @(negedge clk) begin
    logic [8:0] exp;
    if (rst_n) begin
      if (done_lsb) n_done_lsb++;
      if (tx_valid_lsb && ready_lsb) begin
        exp = (exp_lsb_q.size() > 0) ? exp_lsb_q.pop_front() : 9'h100;
        check("lsb_byte", {1'b0, tx_data_lsb}, exp);
        n_bytes_lsb++;
      end
    end
  end

  task automatic start_dump(input bit rnd);
    @(posedge clk);
    #2;
    rand_ready = rnd;
    n_bytes = 0;
    n_done  = 0;
    n_busy  = 0;
    push_frame(regs, 1'b1);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    check("valid_after_start", tx_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input bit lsb);
    int cyc = 0;
    while ((lsb ? busy_lsb : busy) && cyc < 3000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check({tag, "_idle"}, lsb ? busy_lsb : busy, 1'b0);
  endtask

  task automatic wait_bytes(input int target);
    int cyc = 0;
    while (n_bytes < target && cyc < 3000) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    check("reach_byte", n_bytes >= target, 1'b1);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_bytes"}, n_bytes, 129);
    check({tag, "_done"}, n_done, 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    set_regs_default();
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", tx_valid, 1'b0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_lsb_valid", tx_valid_lsb, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Continuous ready: exact cycle count.
    start_dump(1'b0);
    wait_idle("s1", 1'b0);
    end_checks("s1");
    check("s1_busy_cycles", n_busy, 130);

    // Random backpressure.
    start_dump(1'b1);
    wait_idle("s2", 1'b0);
    end_checks("s2");

    // Register file changes right after the capture edge.
    start_dump(1'b1);
    regs[5*W +: W] = 32'h12345678;
    regs[0 +: W]   = 32'hFFFFFFFF;
    wait_idle("s3", 1'b0);
    end_checks("s3");
    set_regs_default();

    // Start pulse mid-dump is ignored.
    start_dump(1'b0);
    wait_bytes(40);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_idle("s4", 1'b0);
    end_checks("s4");
    repeat (5) @(posedge clk);
    #2;
    check("s4_no_requeue", busy, 1'b0);

    // Asynchronous reset mid-dump, then a clean restart.
    start_dump(1'b1);
    wait_bytes(60);
    rst_n = 1'b0;
    #1;
    check("s5_rst_valid", tx_valid, 1'b0);
    check("s5_rst_busy", busy, 1'b0);
    check("s5_rst_done", done, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    check("s5_done_count", n_done, 0);
    repeat (2) @(posedge clk);
    start_dump(1'b0);
    wait_idle("s5", 1'b0);
    end_checks("s5");

    // LSB-first instance.
    regs[1*W +: W] = 32'h11223344;
    @(posedge clk);
    #2;
    n_bytes_lsb = 0;
    n_done_lsb  = 0;
    push_frame(regs, 1'b0);
    start_lsb = 1'b1;
    @(posedge clk);
    #2;
    start_lsb = 1'b0;
    wait_idle("s6", 1'b1);
    check("s6_bytes", n_bytes_lsb, 129);
    check("s6_done", n_done_lsb, 1);
    check("s6_q_empty", exp_lsb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
